// File: rtl/pac_pkg.sv
// Shared definitions for the sum packet format: field positions, packet layout and helpers
// used by the packetizer, the depacketizer and their benches.
package pac_pkg;

  localparam int unsigned SRC_HI = 29;
  localparam int unsigned SRC_LO = 27;
  localparam int unsigned DST_HI = 26;
  localparam int unsigned DST_LO = 24;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned PKT_W  = 32;

  typedef logic [ADDR_W-1:0] node_addr_t;

  typedef struct packed {
    logic [1:0]  rsvd_hi;
    node_addr_t  src;
    node_addr_t  dest;
    logic [14:0] rsvd_mid;
    logic [8:0]  payload;
  } pkt_t;

  // Builds a well-formed packet; reserved bits are always zero.
  function automatic pkt_t build_pkt(input node_addr_t src, input node_addr_t dest,
                                     input logic [8:0] payload);
    pkt_t p;
    p         = '0;
    p.src     = src;
    p.dest    = dest;
    p.payload = payload;
    return p;
  endfunction

  // Bits that must be zero: everything above src, plus the gap between dest and payload.
  function automatic logic [63:0] rsvd_mask(input int unsigned width, input int unsigned pay_w);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < width && (i > SRC_HI || (i < DST_LO && i >= pay_w))) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/pac_unpack_sum_if.sv
// Packet-in / payload-out handshake bundle of the sum depacketizer.
interface pac_unpack_sum_if
  import pac_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PAY_W = 9
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  logic             out_valid;
  logic             out_ready;
  logic [PAY_W-1:0] out_sum;
  node_addr_t       out_src;

  // Upstream router port and downstream PE, seen from outside the block.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_src
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_src
  );

endinterface

// File: rtl/pac_fifo.sv
// Synchronous FIFO with a registered head entry; rdata_o holds its last value once drained.
module pac_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [PtrW-1:0]  rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] head_q, head_d;
  logic             push, pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = head_q;

  assign push = push_i & ~full_o;
  assign pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    head_d = head_q;

    if (push) wr_d = wr_q + PtrW'(1);
    if (pop)  rd_d = rd_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    // The next head is the entry being written now only when nothing older is left.
    if (cnt_d != '0) begin
      head_d = (push && (rd_d == wr_q)) ? wdata_i : mem_q[rd_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/pac_unpack_sum.sv
// Receive-side depacketizer: filters packets by destination and format, buffers matching
// payloads with their source address, and keeps saturating accept/drop statistics.
module pac_unpack_sum
  import pac_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PAY_W     = 9,
  parameter node_addr_t  NODE_ADDR = 3'b000,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pac_unpack_sum_if.slave       bus,
  output logic [CNT_W-1:0]      acc_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  err_fmt
);

  localparam logic [63:0]      RsvdMask64 = rsvd_mask(WIDTH, PAY_W);
  localparam logic [WIDTH-1:0] RsvdMask   = RsvdMask64[WIDTH-1:0];
  localparam int unsigned      FifoCntW   = $clog2(DEPTH + 1);

  typedef struct packed {
    node_addr_t       src;
    logic [PAY_W-1:0] sum;
  } entry_t;

  entry_t              wentry, rentry;
  logic                xfer, fmt_bad, dst_bad, push, drop, pop;
  logic                fifo_full, fifo_empty;
  logic [FifoCntW-1:0] fifo_count;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic                err_q, err_d;

  // Ready depends on stored occupancy only, so a full FIFO stalls even during a pop.
  assign bus.in_ready = (fifo_count < FifoCntW'(DEPTH));
  assign xfer         = bus.in_valid & bus.in_ready;

  assign fmt_bad = |(bus.in_data & RsvdMask);
  assign dst_bad = (bus.in_data[DST_HI:DST_LO] != NODE_ADDR);
  assign push    = xfer & ~fmt_bad & ~dst_bad & ~fifo_full;
  assign drop    = xfer & (fmt_bad | dst_bad);

  assign wentry.src = bus.in_data[SRC_HI:SRC_LO];
  assign wentry.sum = bus.in_data[PAY_W-1:0];

  assign bus.out_valid = ~fifo_empty;
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_sum   = rentry.sum;
  assign bus.out_src   = rentry.src;

  pac_fifo #(
    .Width ($bits(entry_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (rentry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    acc_d  = acc_q;
    drop_d = drop_q;
    err_d  = err_q;
    if (push && (acc_q != '1))  acc_d  = acc_q + CNT_W'(1);
    if (drop && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
    if (xfer && fmt_bad)        err_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  assign acc_cnt  = acc_q;
  assign drop_cnt = drop_q;
  assign err_fmt  = err_q;

endmodule

// File: tb/tb_pac_unpack_sum.sv
// Scoreboard bench for pac_unpack_sum: directed scenarios plus randomized traffic.
module tb_pac_unpack_sum;
  import pac_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SAT   = (1 << CNT_W) - 1;

  typedef struct {
    node_addr_t src;
    logic [8:0] sum;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             err_fmt;

  pac_unpack_sum_if #(.WIDTH(32), .PAY_W(9)) bus ();

  pac_unpack_sum #(
    .WIDTH     (32),
    .PAY_W     (9),
    .NODE_ADDR (3'b000),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .acc_cnt  (acc_cnt),
    .drop_cnt (drop_cnt),
    .err_fmt  (err_fmt)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rand_rdy = 0;
  bit   done3 = 0;

  // Reference model state: what the FIFO should hold and what the counters should read.
  exp_t exp_q[$];
  int   m_acc  = 0;
  int   m_drop = 0;
  bit   m_err  = 0;
  exp_t m_last = '{src: '0, sum: '0};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] d);
    bit ok;
    bit hs;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      hs = bus.in_ready;
      tick();
      ok = hs;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Spec-level classification of a packet that is handshaked at the coming edge.
  task automatic model_accept(input logic [31:0] d);
    pkt_t p;
    exp_t e;
    p = pkt_t'(d);
    if (p.rsvd_hi != 0 || p.rsvd_mid != 0) begin
      m_err = 1;
      if (m_drop < SAT) m_drop++;
    end else if (p.dest != 3'd0) begin
      if (m_drop < SAT) m_drop++;
    end else begin
      e.src = p.src;
      e.sum = p.payload;
      exp_q.push_back(e);
      if (m_acc < SAT) m_acc++;
    end
  endtask

  always @(negedge clk) begin
    bit rdy_m;
    if (!rst_n) begin
      exp_q.delete();
      m_acc  = 0;
      m_drop = 0;
      m_err  = 0;
      m_last = '{src: '0, sum: '0};
    end else begin
      rdy_m = (exp_q.size() < DEPTH);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(rdy_m));
      chk("acc_cnt", 32'(acc_cnt), 32'(m_acc));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("err_fmt", 32'(err_fmt), 32'(m_err));
      if (exp_q.size() != 0) begin
        chk("head_sum", 32'(bus.out_sum), 32'(exp_q[0].sum));
        chk("head_src", 32'(bus.out_src), 32'(exp_q[0].src));
        if (bus.out_ready) m_last = exp_q.pop_front();
      end else begin
        chk("hold_sum", 32'(bus.out_sum), 32'(m_last.sum));
        chk("hold_src", 32'(bus.out_src), 32'(m_last.src));
      end
      if (bus.in_valid && rdy_m) model_accept(bus.in_data);
    end
  end

  initial begin
    logic [31:0] pkt;
    int          c0;
    int          k;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_out_src", 32'(bus.out_src), 32'd0);
    chk("rst_acc", 32'(acc_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_err", 32'(err_fmt), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Matching packet: src 4, payload 300, visible one cycle after the handshake.
    send(32'h2000012C);
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_sum", 32'(bus.out_sum), 32'd300);
    chk("first_src", 32'(bus.out_src), 32'd4);
    chk("first_acc", 32'(acc_cnt), 32'd1);

    // Misrouted packet to node 1.
    send(32'h2100012C);
    chk("misroute_valid", 32'(bus.out_valid), 32'd0);
    chk("misroute_drop", 32'(drop_cnt), 32'd1);
    chk("misroute_err", 32'(err_fmt), 32'd0);
    chk("misroute_hold", 32'(bus.out_sum), 32'd300);

    // Reserved bit 15 set, then ordinary traffic must leave err_fmt set.
    send(32'h2000812C);
    chk("rsvd_drop", 32'(drop_cnt), 32'd2);
    chk("rsvd_err", 32'(err_fmt), 32'd1);
    send(build_pkt(3'd1, 3'd0, 9'd5));
    tick();
    chk("err_sticky", 32'(err_fmt), 32'd1);
    chk("acc_after_rsvd", 32'(acc_cnt), 32'd2);

    // Backpressure: two accepts fill the FIFO, the third waits for the consumer.
    bus.out_ready = 1'b0;
    send(build_pkt(3'd2, 3'd0, 9'd1));
    send(build_pkt(3'd2, 3'd0, 9'd2));
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    fork
      begin
        send(build_pkt(3'd2, 3'd0, 9'd3));
        done3 = 1;
      end
    join_none
    repeat (3) tick();
    chk("stall_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && !done3; i++) tick();
    chk("third_sent", 32'(done3), 32'd1);
    repeat (3) tick();
    chk("bp_acc", 32'(acc_cnt), 32'd5);

    // Streaming: one packet per cycle with a free-running consumer.
    c0 = cyc;
    for (int i = 0; i < 20; i++) send(build_pkt(3'($urandom_range(0, 7)), 3'd0, 9'(i + 40)));
    chk("stream_cycles", 32'(cyc - c0), 32'd20);
    repeat (2) tick();
    chk("stream_acc", 32'(acc_cnt), 32'd25);

    // Async reset with two entries buffered.
    bus.out_ready = 1'b0;
    send(build_pkt(3'd3, 3'd0, 9'd7));
    send(build_pkt(3'd3, 3'd0, 9'd8));
    chk("pre_rst_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_acc", 32'(acc_cnt), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    chk("arst_err", 32'(err_fmt), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("arst_sum", 32'(bus.out_sum), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    send(build_pkt(3'd6, 3'd0, 9'h1A5));
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_sum", 32'(bus.out_sum), 32'h1A5);
    chk("post_rst_src", 32'(bus.out_src), 32'd6);
    chk("post_rst_acc", 32'(acc_cnt), 32'd1);

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) begin
      send(build_pkt(3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)), 9'($urandom)));
    end
    tick();
    chk("drop_sat", 32'(drop_cnt), SAT);
    chk("sat_acc", 32'(acc_cnt), 32'd1);

    // Randomized mix of good, misrouted and malformed packets with a random consumer.
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      pkt = build_pkt(3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                      9'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        k = $urandom_range(0, 16);
        if (k < 2) pkt[30 + k] = 1'b1;
        else pkt[7 + k] = 1'b1;
      end
      send(pkt);
    end
    rand_rdy = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("final_valid", 32'(bus.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
